// File: rtl/test_pattern_gen_pkg.sv
// Shared types and bar-colour tables for the multi-mode test-pattern generator.
package tpg_pkg;

    typedef enum logic [2:0] {
        TPG_EBU75   = 3'd0,
        TPG_EBU100  = 3'd1,
        TPG_RAMP    = 3'd2,
        TPG_CHECKER = 3'd3,
        TPG_GRID    = 3'd4,
        TPG_SOLID   = 3'd5,
        TPG_SCROLL  = 3'd6,
        TPG_BLACK   = 3'd7
    } tpg_mode_e;

    typedef struct packed {
        logic        [7:0] y;
        logic signed [7:0] u;
        logic signed [7:0] v;
    } yuv_t;

    function automatic yuv_t mk_yuv(input int y, input int u, input int v);
        yuv_t r;
        r.y = 8'(y);
        r.u = 8'(u);
        r.v = 8'(v);
        return r;
    endfunction

    // Bars in order W,Y,C,G,M,R,B,K
    localparam yuv_t EBU75_LUT [8] = '{
        mk_yuv(255,   0,   0), mk_yuv(168, -41,   9),
        mk_yuv(133,  14, -58), mk_yuv(112, -27, -49),
        mk_yuv( 76,  27,  49), mk_yuv( 56, -14,  58),
        mk_yuv( 20,  41,  -9), mk_yuv(  0,   0,   0)
    };

    localparam yuv_t EBU100_LUT [8] = '{
        mk_yuv(255,   0,   0), mk_yuv(226, -56,  13),
        mk_yuv(179,  19, -79), mk_yuv(150, -37, -66),
        mk_yuv(105,  37,  66), mk_yuv( 76, -19,  79),
        mk_yuv( 29,  56, -13), mk_yuv(  0,   0,   0)
    };

endpackage

// File: rtl/test_pattern_gen_if.sv
// Timing strobes, pattern configuration and pixel output of the test-pattern generator.
interface test_pattern_gen_if;
    import tpg_pkg::*;

    logic              newframe;
    logic              newline;
    logic              newpixel;
    logic              visible_line;
    logic              visible_window;
    tpg_mode_e         mode;
    logic        [7:0] solid_y;
    logic signed [7:0] solid_u;
    logic signed [7:0] solid_v;
    logic        [3:0] scroll_step;
    logic        [7:0] luma;
    logic signed [7:0] yuv_u;
    logic signed [7:0] yuv_v;
    logic              active;

    // Timing generator / configuration side
    modport master (
        output newframe, newline, newpixel, visible_line, visible_window,
        output mode, solid_y, solid_u, solid_v, scroll_step,
        input  luma, yuv_u, yuv_v, active
    );

    // Pattern generator side
    modport slave (
        input  newframe, newline, newpixel, visible_line, visible_window,
        input  mode, solid_y, solid_u, solid_v, scroll_step,
        output luma, yuv_u, yuv_v, active
    );

endinterface

// File: rtl/test_pattern_gen_bar_rom.sv
// Colour-bar lookup shared by the 75%, 100% and scrolling bar modes.
module tpg_bar_rom
    import tpg_pkg::*;
(
    input  logic       i_sel100,
    input  logic [2:0] i_bar,
    output yuv_t       o_yuv
);

    // Select the bar colour from the 75% or 100% table
    always_comb begin
        o_yuv = '0;
        if (i_sel100) begin
            o_yuv = EBU100_LUT[i_bar];
        end else begin
            o_yuv = EBU75_LUT[i_bar];
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode video test-pattern source: counts visible pixels/lines from the
// timing strobes and emits one registered Y/U/V sample per clock.
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int XW         = 9,
    parameter int YW         = 9,
    parameter int CHECK_LOG2 = 4,
    parameter int GRID_THICK = 1
)(
    input  logic              clk,
    input  logic              rst,
    test_pattern_gen_if.slave bus
);

    logic [XW-1:0]         r_pixel_x;
    logic [YW-1:0]         r_line_y;
    logic [XW-1:0]         r_scroll;
    tpg_mode_e             r_mode;
    yuv_t                  r_solid;

    logic [XW-1:0]         w_scroll_x;
    logic [2:0]            w_bar;
    logic                  w_sel100;
    yuv_t                  w_bar_yuv;
    yuv_t                  w_pix;
    logic [CHECK_LOG2-1:0] w_cell_x;
    logic [CHECK_LOG2-1:0] w_cell_y;

    assign w_scroll_x = r_pixel_x + r_scroll;
    assign w_bar      = (r_mode == TPG_SCROLL) ? w_scroll_x[XW-1 -: 3] : r_pixel_x[XW-1 -: 3];
    assign w_sel100   = (r_mode == TPG_EBU100);
    assign w_cell_x   = r_pixel_x[CHECK_LOG2-1:0];
    assign w_cell_y   = r_line_y[CHECK_LOG2-1:0];

    tpg_bar_rom u_bar_rom (
        .i_sel100 (w_sel100),
        .i_bar    (w_bar),
        .o_yuv    (w_bar_yuv)
    );

    // Pixel/line counters and frame-synchronous latching of mode, solid colour and scroll
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_x <= '0;
            r_line_y  <= '0;
            r_scroll  <= '0;
            r_mode    <= TPG_EBU75;
            r_solid   <= '0;
        end else begin
            if (bus.newline) begin
                r_pixel_x <= '0;
            end else if (bus.visible_window && bus.newpixel && (r_pixel_x != '1)) begin
                r_pixel_x <= r_pixel_x + 1'b1;
            end

            if (bus.newframe) begin
                r_line_y  <= '0;
                r_mode    <= bus.mode;
                r_solid   <= mk_yuv(int'(bus.solid_y), int'(bus.solid_u), int'(bus.solid_v));
                r_scroll  <= r_scroll + XW'(bus.scroll_step);
            end else if (bus.newline && bus.visible_line && (r_line_y != '1)) begin
                r_line_y  <= r_line_y + 1'b1;
            end
        end
    end

    // Pattern value for the current counters and latched mode
    always_comb begin
        w_pix = '0;
        case (r_mode)
            TPG_EBU75, TPG_EBU100, TPG_SCROLL: w_pix = w_bar_yuv;
            TPG_RAMP:    w_pix.y = r_pixel_x[XW-1 -: 8];
            TPG_CHECKER: w_pix.y = (r_pixel_x[CHECK_LOG2] ^ r_line_y[CHECK_LOG2]) ? 8'd255 : 8'd0;
            TPG_GRID:    w_pix.y = ((w_cell_x < CHECK_LOG2'(GRID_THICK)) ||
                                    (w_cell_y < CHECK_LOG2'(GRID_THICK))) ? 8'd255 : 8'd0;
            TPG_SOLID:   w_pix = r_solid;
            default:     w_pix = '0;
        endcase
    end

    // Registered pixel output, blanked outside the visible window
    always_ff @(posedge clk) begin
        if (rst || !bus.visible_window) begin
            bus.luma   <= '0;
            bus.yuv_u  <= '0;
            bus.yuv_v  <= '0;
            bus.active <= 1'b0;
        end else begin
            bus.luma   <= w_pix.y;
            bus.yuv_u  <= w_pix.u;
            bus.yuv_v  <= w_pix.v;
            bus.active <= 1'b1;
        end
    end

endmodule
